// File: rtl/sd_frame_reader.sv
// Sector sequencer in front of the SD SPI single-block reader: issues SEC_NUM consecutive
// sector reads per frame, counts the returned words and reports completion and errors.
module sd_frame_reader #(
  parameter int unsigned SEC_NUM = 1200,
  parameter int unsigned WORDS   = 256,
  parameter int unsigned GAP_CYC = 16,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        frame_req,
  input  logic [31:0] frame_base,
  input  logic        rd_busy,
  input  logic        rd_val_en,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [15:0] sec_cnt,
  output logic        err_timeout,
  output logic        err_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_REQ, S_WAIT, S_CHECK, S_GAP, S_DONE, S_ERR
  } state_e;

  localparam logic [15:0] SEC_LAST  = 16'(SEC_NUM);
  localparam logic [8:0]  WORDS_EXP = 9'(WORDS);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [23:0] TMO_LAST  = TIMEOUT - 24'd1;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] sec_cnt_q, sec_cnt_d;
  logic        err_to_q, err_to_d;
  logic        err_len_q, err_len_d;
  logic [23:0] tmo_q, tmo_d;
  logic [8:0]  word_q, word_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] sec_next;

  assign sec_next = sec_cnt_q + 16'd1;

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sec_cnt_d = sec_cnt_q;
    err_to_d  = err_to_q;
    err_len_d = err_len_q;
    tmo_d     = tmo_q;
    word_d    = word_q;
    gap_d     = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          addr_d    = frame_base;
          sec_cnt_d = '0;
          err_to_d  = 1'b0;
          err_len_d = 1'b0;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (sd_init_done) begin
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_busy) begin
          tmo_d   = '0;
          word_d  = '0;
          state_d = S_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_ERR;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_WAIT: begin
        // The word counter saturates so an overlong sector still reads as a length error.
        if (rd_val_en && (word_q != 9'h1FF)) word_d = word_q + 9'd1;
        if (!rd_busy) begin
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_ERR;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_CHECK: begin
        if (word_q != WORDS_EXP) err_len_d = 1'b1;
        sec_cnt_d = sec_next;
        if (sec_next == SEC_LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 32'd1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          tmo_d   = '0;
          state_d = S_REQ;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sec_cnt_q <= '0;
      err_to_q  <= 1'b0;
      err_len_q <= 1'b0;
      tmo_q     <= '0;
      word_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sec_cnt_q <= sec_cnt_d;
      err_to_q  <= err_to_d;
      err_len_q <= err_len_d;
      tmo_q     <= tmo_d;
      word_q    <= word_d;
      gap_q     <= gap_d;
    end
  end

  // Control outputs decode straight from the state register, so reset clears them on its edge.
  assign rd_start_en = (state_q == S_REQ);
  assign frame_busy  = (state_q == S_ARM) || (state_q == S_REQ) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK) || (state_q == S_GAP);
  assign frame_done  = (state_q == S_DONE);
  assign rd_sec_addr = addr_q;
  assign sec_cnt     = sec_cnt_q;
  assign err_timeout = err_to_q;
  assign err_len     = err_len_q;

endmodule

// File: tb/tb_sd_frame_reader.sv
// Bench for sd_frame_reader: three parameterisations share the stimulus, a behavioural
// reader answers the selected one and a queue of expected sector addresses checks every read.
module tb_sd_frame_reader;

  localparam int WORDS = 256;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        sd_init_done;
  logic        frame_req;
  logic [31:0] frame_base;
  logic        rd_busy;
  logic        rd_val_en;
  logic [1:0]  sel;

  logic [2:0]  req_v, st_v, busy_v, done_v, eto_v, elen_v;
  logic [31:0] addr_v [3];
  logic [15:0] cnt_v  [3];

  logic        rd_start_en, frame_busy, frame_done, err_timeout, err_len;
  logic [31:0] rd_sec_addr;
  logic [15:0] sec_cnt;

  int          total, bad;
  logic [31:0] exp_q [$];
  int          rdr_starts, rdr_sec, short_idx;
  bit          rdr_on, rdr_idle;

  always #5 clk_ref = ~clk_ref;

  // Instance 0: 3 sectors, instance 1: 2 sectors with a short timeout, instance 2: 2 sectors.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned SN = (g == 0) ? 3 : 2;
    localparam logic [23:0] TO = (g == 1) ? 24'd100 : 24'd2000;
    assign req_v[g] = frame_req && (sel == 2'(g));
    sd_frame_reader #(.SEC_NUM(SN), .WORDS(WORDS), .GAP_CYC(16), .TIMEOUT(TO)) dut (
      .clk_ref      (clk_ref),
      .rst          (rst),
      .sd_init_done (sd_init_done),
      .frame_req    (req_v[g]),
      .frame_base   (frame_base),
      .rd_busy      (rd_busy),
      .rd_val_en    (rd_val_en),
      .rd_start_en  (st_v[g]),
      .rd_sec_addr  (addr_v[g]),
      .frame_busy   (busy_v[g]),
      .frame_done   (done_v[g]),
      .sec_cnt      (cnt_v[g]),
      .err_timeout  (eto_v[g]),
      .err_len      (elen_v[g])
    );
  end

  assign rd_start_en = st_v[sel];
  assign rd_sec_addr = addr_v[sel];
  assign frame_busy  = busy_v[sel];
  assign frame_done  = done_v[sel];
  assign sec_cnt     = cnt_v[sel];
  assign err_timeout = eto_v[sel];
  assign err_len     = elen_v[sel];

  // Reader model: on a start level it pops the expected address, then returns a sector.
  task automatic reader();
    int n;
    logic [31:0] exp_addr;
    forever begin
      @(negedge clk_ref);
      if (rdr_on && rd_start_en && !rst) begin
        rdr_starts++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sector_addr: start at addr %h, expected no read", rd_sec_addr);
        end else begin
          exp_addr = exp_q.pop_front();
          if (rd_sec_addr !== exp_addr) begin
            bad++;
            $display("FAIL sector_addr: got %h want %h", rd_sec_addr, exp_addr);
          end
        end
        n = (rdr_sec == short_idx) ? WORDS - 1 : WORDS;
        rdr_sec++;
        rdr_idle = 1'b0;
        repeat (2) @(negedge clk_ref);
        rd_busy = 1'b1;
        @(negedge clk_ref);
        for (int k = 0; k < n; k++) begin
          rd_val_en = 1'b1;
          @(negedge clk_ref);
        end
        rd_val_en = 1'b0;
        repeat (2) @(negedge clk_ref);
        rd_busy  = 1'b0;
        rdr_idle = 1'b1;
      end
    end
  endtask

  task automatic push_addrs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic pulse_req(input logic [31:0] base);
    @(negedge clk_ref);
    frame_base = base;
    frame_req  = 1'b1;
    @(negedge clk_ref);
    frame_req  = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit to, output bit done,
                          output logic [15:0] sc, output bit et, output bit el);
    to = 1'b1; done = 1'b0; sc = '0; et = 1'b0; el = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      if (!frame_busy) begin
        to = 1'b0; done = frame_done; sc = sec_cnt; et = err_timeout; el = err_len;
        break;
      end
    end
  endtask

  task automatic wait_rdr_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_ref);
      if (rdr_idle && !rd_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sel = 2'd0;
    repeat (3) @(negedge clk_ref);
    total++;
    if ({st_v, busy_v, done_v, eto_v, elen_v} !== 15'd0) begin
      bad++; $display("FAIL reset_flags: got %b want 0", {st_v, busy_v, done_v, eto_v, elen_v});
    end
    total++;
    if ({addr_v[0], addr_v[1], addr_v[2], cnt_v[0], cnt_v[1], cnt_v[2]} !== 144'd0) begin
      bad++; $display("FAIL reset_regs: addr0=%h cnt0=%0d want 0", addr_v[0], cnt_v[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to, done, et, el;
    logic [15:0] sc;
    int n;
    sel = 2'd0; rdr_sec = 0; rdr_starts = 0; short_idx = -1;
    push_addrs(32'h100, 3);
    pulse_req(32'h100);
    total++;
    if ({frame_busy, rd_start_en} !== 2'b10 || rd_sec_addr !== 32'h100) begin
      bad++; $display("FAIL basic_accept: busy/start=%b addr=%h want 10/100",
                      {frame_busy, rd_start_en}, rd_sec_addr);
    end
    @(negedge clk_ref);
    total++;
    if (rd_start_en !== 1'b1) begin bad++; $display("FAIL basic_latency: start=%b want 1", rd_start_en); end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_ref);
      if (sec_cnt == 16'd1) break;
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_ref);
      n++;
      if (rd_start_en) break;
    end
    total++;
    if (n != 16) begin bad++; $display("FAIL basic_gap: rise after %0d cycles want 16", n); end
    wait_end(3000, to, done, sc, et, el);
    total++;
    if (to || !done || sc !== 16'd3) begin
      bad++; $display("FAIL basic_done: timeout=%0b done=%0b sec_cnt=%0d want 0/1/3", to, done, sc);
    end
    total++;
    if (et || el) begin bad++; $display("FAIL basic_errors: to=%0b len=%0b want 0/0", et, el); end
    total++;
    if (rdr_starts != 3 || exp_q.size() != 0) begin
      bad++; $display("FAIL basic_starts: starts=%0d left=%0d want 3/0", rdr_starts, exp_q.size());
    end
  endtask

  task automatic test_init_wait();
    bit to, done, et, el;
    logic [15:0] sc;
    int hi;
    sel = 2'd0; rdr_sec = 0; rdr_starts = 0; sd_init_done = 1'b0;
    push_addrs(32'h40, 3);
    pulse_req(32'h40);
    hi = 0;
    repeat (500) begin
      @(negedge clk_ref);
      if (rd_start_en) hi++;
    end
    total++;
    if (hi != 0 || frame_busy !== 1'b1) begin
      bad++; $display("FAIL init_hold: start cycles=%0d busy=%b want 0/1", hi, frame_busy);
    end
    sd_init_done = 1'b1;
    wait_end(3000, to, done, sc, et, el);
    total++;
    if (to || !done || sc !== 16'd3 || et || el) begin
      bad++; $display("FAIL init_done: to=%0b done=%0b sc=%0d et=%0b el=%0b want 0/1/3/0/0",
                      to, done, sc, et, el);
    end
    total++;
    if (rdr_starts != 3 || exp_q.size() != 0) begin
      bad++; $display("FAIL init_starts: starts=%0d left=%0d want 3/0", rdr_starts, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int n, hi;
    bit done, eto;
    sel = 2'd1; rdr_on = 1'b0;
    pulse_req(32'h77);
    n = 0; hi = 0; done = 1'b0; eto = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_ref);
      n++;
      if (rd_start_en) hi++;
      if (!frame_busy) begin done = frame_done; eto = err_timeout; break; end
    end
    total++;
    if (n != 101 || hi != 100) begin
      bad++; $display("FAIL timeout_len: busy for %0d, start for %0d, want 101/100", n, hi);
    end
    total++;
    if (done !== 1'b0 || eto !== 1'b1) begin
      bad++; $display("FAIL timeout_flags: done=%0b err_timeout=%0b want 0/1", done, eto);
    end
    @(negedge clk_ref);
    total++;
    if (err_timeout !== 1'b1 || frame_busy !== 1'b0 || sec_cnt !== 16'd0) begin
      bad++; $display("FAIL timeout_sticky: et=%0b busy=%0b sc=%0d want 1/0/0",
                      err_timeout, frame_busy, sec_cnt);
    end
    rdr_on = 1'b1;
  endtask

  task automatic test_len_err();
    bit to, done, et, el;
    logic [15:0] sc;
    sel = 2'd0; rdr_sec = 0; short_idx = 1;
    push_addrs(32'h500, 3);
    pulse_req(32'h500);
    wait_end(3000, to, done, sc, et, el);
    total++;
    if (to || !done || sc !== 16'd3 || !el || et) begin
      bad++; $display("FAIL len_frame: to=%0b done=%0b sc=%0d el=%0b et=%0b want 0/1/3/1/0",
                      to, done, sc, el, et);
    end
    short_idx = -1; rdr_sec = 0;
    push_addrs(32'h600, 3);
    pulse_req(32'h600);
    total++;
    if (err_len !== 1'b0) begin bad++; $display("FAIL len_clear: err_len=%0b want 0", err_len); end
    wait_end(3000, to, done, sc, et, el);
    total++;
    if (to || !done || el || exp_q.size() != 0) begin
      bad++; $display("FAIL len_next: to=%0b done=%0b el=%0b left=%0d want 0/1/0/0",
                      to, done, el, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    bit to, done, et, el, ok;
    logic [15:0] sc;
    sel = 2'd0; rdr_sec = 0;
    push_addrs(32'h200, 3);
    pulse_req(32'h200);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_ref);
      if (sec_cnt == 16'd1 && rd_busy) break;
    end
    repeat (50) @(negedge clk_ref);
    total++;
    if (sec_cnt !== 16'd1 || frame_busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre: sc=%0d busy=%0b want 1/1", sec_cnt, frame_busy);
    end
    rst = 1'b1;
    @(negedge clk_ref);
    rst = 1'b0;
    total++;
    if ({rd_start_en, frame_busy, frame_done, err_timeout, err_len} !== 5'd0 ||
        sec_cnt !== 16'd0 || rd_sec_addr !== 32'd0) begin
      bad++; $display("FAIL rst_mid: flags=%b sc=%0d addr=%h want 0/0/0",
                      {rd_start_en, frame_busy, frame_done, err_timeout, err_len}, sec_cnt, rd_sec_addr);
    end
    wait_rdr_idle(ok);
    total++;
    if (!ok || frame_done !== 1'b0) begin
      bad++; $display("FAIL rst_quiet: reader idle=%0b done=%0b want 1/0", ok, frame_done);
    end
    exp_q.delete();
    rdr_sec = 0;
    push_addrs(32'h300, 3);
    pulse_req(32'h300);
    total++;
    if (rd_sec_addr !== 32'h300) begin bad++; $display("FAIL rst_newbase: addr=%h want 300", rd_sec_addr); end
    wait_end(3000, to, done, sc, et, el);
    total++;
    if (to || !done || sc !== 16'd3 || et || el || exp_q.size() != 0) begin
      bad++; $display("FAIL rst_restart: to=%0b done=%0b sc=%0d et=%0b el=%0b left=%0d",
                      to, done, sc, et, el, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit to, done, et, el;
    logic [15:0] sc;
    sel = 2'd2; rdr_sec = 0; rdr_starts = 0;
    push_addrs(32'hFFFF_FFFF, 2);
    pulse_req(32'hFFFF_FFFF);
    repeat (30) @(negedge clk_ref);
    pulse_req(32'h1234);
    total++;
    if (rd_sec_addr !== 32'hFFFF_FFFF || frame_busy !== 1'b1) begin
      bad++; $display("FAIL wrap_ignore: addr=%h busy=%0b want ffffffff/1", rd_sec_addr, frame_busy);
    end
    wait_end(3000, to, done, sc, et, el);
    total++;
    if (to || !done || sc !== 16'd2 || et || el) begin
      bad++; $display("FAIL wrap_done: to=%0b done=%0b sc=%0d et=%0b el=%0b want 0/1/2/0/0",
                      to, done, sc, et, el);
    end
    total++;
    if (rdr_starts != 2 || exp_q.size() != 0 || rd_sec_addr !== 32'd0) begin
      bad++; $display("FAIL wrap_addr: starts=%0d left=%0d addr=%h want 2/0/0",
                      rdr_starts, exp_q.size(), rd_sec_addr);
    end
  endtask

  initial begin
    rst = 1'b1; sd_init_done = 1'b1; frame_req = 1'b0; frame_base = '0;
    rd_busy = 1'b0; rd_val_en = 1'b0; sel = 2'd0;
    total = 0; bad = 0; rdr_starts = 0; rdr_sec = 0; short_idx = -1;
    rdr_on = 1'b1; rdr_idle = 1'b1;
    fork
      reader();
    join_none
    test_reset();
    test_basic();
    test_init_wait();
    test_timeout();
    test_len_err();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
